// File: rtl/teller_dispatch.sv
// teller_dispatch
// Calls the head of the queue to a free, in-service teller. Tellers are chosen
// round-robin. After a call, the block waits for the back-end photocell to show
// that the person has left the queue. If that does not happen within
// TIMEOUT_CYC cycles, the call is dropped as a no-show.
//
// Ports
//   clck          system clock, rising edge
//   rst           asynchronous, active-low reset
//   T_Count       tellers in service (00 none, 01 t0, 10 t0-1, 11 t0-2)
//   empt_flag     queue empty, from the queue machine
//   BE_photocell  back-end sensor level; a rising edge means a person left
//   teller_done   one-cycle pulse per teller: customer finished
//   call_valid    a call is being displayed
//   call_teller   called teller number 1..3, 0 when no call
//   call_ticket   ticket number of the current or next call
//   busy          per-teller serving flag
//   served        one-cycle pulse: called person confirmed at back-end
//   noshow        one-cycle pulse: call timed out
module teller_dispatch #(
  parameter int TIMEOUT_CYC = 16,
  parameter int TICKET_W    = 4
) (
  input  logic                clck,
  input  logic                rst,
  input  logic [1:0]          T_Count,
  input  logic                empt_flag,
  input  logic                BE_photocell,
  input  logic [2:0]          teller_done,
  output logic                call_valid,
  output logic [1:0]          call_teller,
  output logic [TICKET_W-1:0] call_ticket,
  output logic [2:0]          busy,
  output logic                served,
  output logic                noshow
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  state_t                state, state_n;
  logic                  be_prev;
  logic [TMR_W-1:0]      timer, timer_n;
  logic [1:0]            ptr, ptr_n;
  logic [1:0]            cur_idx, cur_idx_n;
  logic                  valid_n;
  logic [1:0]            teller_n;
  logic [TICKET_W-1:0]   ticket_n;
  logic [2:0]            busy_n;
  logic                  served_n, noshow_n;

  logic [2:0]            active_mask;
  logic [2:0]            eligible;
  logic                  be_edge;
  logic [1:0]            cand1, cand2;
  logic                  grant_any;
  logic [1:0]            grant_idx;

  // Tellers in service always form a contiguous group that starts at teller0.
  always_comb begin
    active_mask = 3'b000;
    case (T_Count)
      2'b01:   active_mask = 3'b001;
      2'b10:   active_mask = 3'b011;
      2'b11:   active_mask = 3'b111;
      default: active_mask = 3'b000;
    endcase
  end

  assign eligible  = active_mask & ~busy;
  assign be_edge   = BE_photocell & ~be_prev;
  assign grant_any = |eligible;

  // The search order is pointer, pointer+1, pointer+2, all taken modulo 3.
  assign cand1 = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
  assign cand2 = (ptr == 2'd0) ? 2'd2 : ptr - 2'd1;

  always_comb begin
    grant_idx = cand2;
    if (eligible[ptr]) begin
      grant_idx = ptr;
    end else if (eligible[cand1]) begin
      grant_idx = cand1;
    end
  end

  // Next-state and output logic. A BE edge is checked before the timeout,
  // so a departure on the final cycle still counts as served. teller_done is
  // applied first, which means a busy set made in the same cycle takes priority.
  always_comb begin
    state_n   = state;
    timer_n   = timer;
    ptr_n     = ptr;
    cur_idx_n = cur_idx;
    valid_n   = call_valid;
    teller_n  = call_teller;
    ticket_n  = call_ticket;
    busy_n    = busy & ~teller_done;
    served_n  = 1'b0;
    noshow_n  = 1'b0;
    case (state)
      IDLE: begin
        if (grant_any && !empt_flag) begin
          valid_n   = 1'b1;
          teller_n  = grant_idx + 2'd1;
          cur_idx_n = grant_idx;
          timer_n   = '0;
          ptr_n     = (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
          state_n   = WAIT;
        end
      end
      WAIT: begin
        timer_n = timer + TMR_W'(1);
        if (be_edge) begin
          busy_n[cur_idx] = 1'b1;
          served_n        = 1'b1;
          ticket_n        = call_ticket + TICKET_W'(1);
          valid_n         = 1'b0;
          teller_n        = 2'd0;
          state_n         = IDLE;
        end else if (timer == TMR_LAST) begin
          noshow_n = 1'b1;
          ticket_n = call_ticket + TICKET_W'(1);
          valid_n  = 1'b0;
          teller_n = 2'd0;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // All state, including the displayed call, is cleared as soon as reset is
  // asserted. A call that was pending therefore produces no served or noshow
  // pulse.
  always_ff @(posedge clck or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      be_prev     <= 1'b0;
      timer       <= '0;
      ptr         <= 2'd0;
      cur_idx     <= 2'd0;
      call_valid  <= 1'b0;
      call_teller <= 2'd0;
      call_ticket <= '0;
      busy        <= 3'b000;
      served      <= 1'b0;
      noshow      <= 1'b0;
    end else begin
      state       <= state_n;
      be_prev     <= BE_photocell;
      timer       <= timer_n;
      ptr         <= ptr_n;
      cur_idx     <= cur_idx_n;
      call_valid  <= valid_n;
      call_teller <= teller_n;
      call_ticket <= ticket_n;
      busy        <= busy_n;
      served      <= served_n;
      noshow      <= noshow_n;
    end
  end

endmodule

// File: tb/tb_teller_dispatch.sv
// tb_teller_dispatch
// Directed test of teller_dispatch. The stimulus code pushes each expected call,
// served or noshow event into a queue. A monitor running on the falling clock
// edge pops the queue and compares it with each event the DUT produces.
module tb_teller_dispatch;

  localparam int TIMEOUT_CYC = 16;
  localparam int TICKET_W    = 4;

  typedef enum int {
    EV_CALL,
    EV_SERVED,
    EV_NOSHOW
  } ev_kind_t;

  typedef struct {
    ev_kind_t kind;
    int       teller;
    int       ticket;
    int       busy;
    int       lat;
  } ev_t;

  logic                clck = 1'b0;
  logic                rst = 1'b0;
  logic [1:0]          T_Count = 2'b11;
  logic                empt_flag = 1'b0;
  logic                BE_photocell = 1'b0;
  logic [2:0]          teller_done = 3'b000;
  logic                call_valid;
  logic [1:0]          call_teller;
  logic [TICKET_W-1:0] call_ticket;
  logic [2:0]          busy;
  logic                served;
  logic                noshow;

  ev_t  exp_q[$];
  int   num_checks = 0;
  int   num_fail = 0;
  int   cyc = 0;
  int   call_cyc = 0;
  logic prev_cv = 1'b0;

  teller_dispatch #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TICKET_W(TICKET_W)
  ) dut (
    .clck(clck),
    .rst(rst),
    .T_Count(T_Count),
    .empt_flag(empt_flag),
    .BE_photocell(BE_photocell),
    .teller_done(teller_done),
    .call_valid(call_valid),
    .call_teller(call_teller),
    .call_ticket(call_ticket),
    .busy(busy),
    .served(served),
    .noshow(noshow)
  );

  always #5 clck = ~clck;

  task automatic checkOutput(input string name, input int actual, input int expected);
    num_checks++;
    if (actual != expected) begin
      num_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic push_ev(input ev_kind_t kind, input int teller, input int ticket,
                         input int busy_v, input int lat);
    ev_t e;
    e.kind   = kind;
    e.teller = teller;
    e.ticket = ticket;
    e.busy   = busy_v;
    e.lat    = lat;
    exp_q.push_back(e);
  endtask

  task automatic monitor_event(input ev_kind_t kind, input int lat);
    ev_t e;
    if (exp_q.size() == 0) begin
      num_checks++;
      num_fail++;
      $display("[TB] FAIL unexpected_event: got %s at cycle %0d, expected none", kind.name(), cyc);
    end else begin
      e = exp_q.pop_front();
      checkOutput("event_kind", int'(kind), int'(e.kind));
      if (e.kind == EV_CALL) begin
        checkOutput("call_teller", int'(call_teller), e.teller);
        checkOutput("call_ticket", int'(call_ticket), e.ticket);
      end else begin
        checkOutput("resolve_ticket", int'(call_ticket), e.ticket);
        checkOutput("resolve_busy", int'(busy), e.busy);
        checkOutput("resolve_latency", lat, e.lat);
        checkOutput("resolve_call_cleared", int'(call_valid), 0);
      end
    end
  endtask

  // The monitor samples on the falling edge. It is paused while reset is
  // asserted, and it treats each rise of call_valid as a new call.
  always @(negedge clck) begin
    if (!rst) begin
      prev_cv = 1'b0;
    end else begin
      cyc++;
      if (served || noshow) begin
        checkOutput("served_noshow_exclusive", int'(served && noshow), 0);
      end
      if (call_valid && !prev_cv) begin
        call_cyc = cyc;
        monitor_event(EV_CALL, 0);
      end
      if (served) monitor_event(EV_SERVED, cyc - call_cyc);
      if (noshow) monitor_event(EV_NOSHOW, cyc - call_cyc);
      prev_cv = call_valid;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clck);
    #1;
  endtask

  // Pulses teller_done for one cycle, then waits an extra hold cycles.
  task automatic applyStimulus(input logic [2:0] done, input int hold);
    teller_done = done;
    tick(1);
    teller_done = 3'b000;
    if (hold > 0) tick(hold);
  endtask

  task automatic wait_call();
    int n = 0;
    while (!call_valid && n < 60) begin
      tick(1);
      n++;
    end
    checkOutput("call_appears", int'(call_valid), 1);
  endtask

  task automatic wait_resolve();
    int n = 0;
    while (!(served || noshow) && n < 60) begin
      tick(1);
      n++;
    end
    checkOutput("resolve_appears", int'(served || noshow), 1);
  endtask

  // Raises BE n_wait cycles after the call became visible, which puts the
  // served pulse n_wait+1 cycles after call_valid rose.
  task automatic confirm(input int n_wait);
    if (n_wait > 0) tick(n_wait);
    BE_photocell = 1'b1;
    tick(1);
    BE_photocell = 1'b0;
    tick(1);
  endtask

  initial begin
    #12;
    checkOutput("reset_call_valid", int'(call_valid), 0);
    checkOutput("reset_call_teller", int'(call_teller), 0);
    checkOutput("reset_call_ticket", int'(call_ticket), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_served", int'(served), 0);
    checkOutput("reset_noshow", int'(noshow), 0);

    // First call goes to teller 1. Then round-robin hands out tellers 2 and 3.
    push_ev(EV_CALL, 1, 0, 0, 0);
    @(posedge clck);
    #1 rst = 1'b1;
    wait_call();
    push_ev(EV_SERVED, 0, 1, 3'b001, 3);
    push_ev(EV_CALL, 2, 1, 0, 0);
    confirm(2);
    wait_call();
    push_ev(EV_SERVED, 0, 2, 3'b011, 1);
    push_ev(EV_CALL, 3, 2, 0, 0);
    confirm(0);
    wait_call();
    push_ev(EV_SERVED, 0, 3, 3'b111, 2);
    confirm(1);
    tick(4);
    checkOutput("all_busy_no_call", int'(call_valid), 0);
    checkOutput("all_busy_mask", int'(busy), 7);

    // A BE edge while IDLE must be ignored.
    confirm(0);
    tick(2);
    checkOutput("idle_be_busy_held", int'(busy), 7);

    // Teller 2 is freed and called, but the person never shows. Tellers 1 and 3
    // are freed meanwhile, so after the noshow the pointer leads to teller 3.
    push_ev(EV_CALL, 2, 3, 0, 0);
    push_ev(EV_NOSHOW, 0, 4, 3'b000, TIMEOUT_CYC);
    push_ev(EV_CALL, 3, 4, 0, 0);
    applyStimulus(3'b010, 0);
    wait_call();
    tick(3);
    applyStimulus(3'b101, 0);
    wait_resolve();

    // The BE edge lands on the last timer cycle, so the call counts as served.
    wait_call();
    push_ev(EV_SERVED, 0, 5, 3'b100, TIMEOUT_CYC);
    push_ev(EV_CALL, 1, 5, 0, 0);
    confirm(TIMEOUT_CYC - 1);

    // T_Count drops during WAIT, and the call still completes.
    wait_call();
    T_Count = 2'b01;
    push_ev(EV_SERVED, 0, 6, 3'b101, 2);
    confirm(1);
    tick(3);
    checkOutput("tcount01_teller1_busy_no_call", int'(call_valid), 0);

    // With only teller 1 in service, every call goes to teller 1, and the
    // ticket wraps from 15 to 0.
    for (int t = 6; t < 17; t++) begin
      push_ev(EV_CALL, 1, t % 16, 0, 0);
      applyStimulus((t == 6) ? 3'b111 : 3'b001, 0);
      wait_call();
      push_ev(EV_SERVED, 0, (t + 1) % 16, 3'b001, 1);
      confirm(0);
    end

    // An empty queue, or no tellers in service, means no calls.
    empt_flag = 1'b1;
    applyStimulus(3'b001, 4);
    checkOutput("empty_no_call", int'(call_valid), 0);
    checkOutput("empty_busy_cleared", int'(busy), 0);
    T_Count = 2'b00;
    empt_flag = 1'b0;
    tick(4);
    checkOutput("tcount00_no_call", int'(call_valid), 0);

    // When empt_flag rises during WAIT, the call still resolves.
    push_ev(EV_CALL, 2, 1, 0, 0);
    T_Count = 2'b11;
    wait_call();
    empt_flag = 1'b1;
    push_ev(EV_SERVED, 0, 2, 3'b010, 2);
    confirm(1);
    tick(3);
    checkOutput("empty_after_wait_no_call", int'(call_valid), 0);

    // An asynchronous reset in the middle of WAIT clears everything
    // before the next clock edge.
    push_ev(EV_CALL, 3, 2, 0, 0);
    empt_flag = 1'b0;
    wait_call();
    tick(2);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_rst_call_valid", int'(call_valid), 0);
    checkOutput("async_rst_call_teller", int'(call_teller), 0);
    checkOutput("async_rst_call_ticket", int'(call_ticket), 0);
    checkOutput("async_rst_busy", int'(busy), 0);
    checkOutput("async_rst_served", int'(served), 0);
    checkOutput("async_rst_noshow", int'(noshow), 0);
    checkOutput("queue_empty_at_reset", exp_q.size(), 0);
    push_ev(EV_CALL, 1, 0, 0, 0);
    @(posedge clck);
    #1 rst = 1'b1;
    wait_call();
    empt_flag = 1'b1;
    push_ev(EV_SERVED, 0, 1, 3'b001, 1);
    confirm(0);
    tick(4);
    checkOutput("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule

// File: doc/teller_dispatch.md
Name: teller_dispatch

Overview:
- Teller-side counterpart of the queue machine. The queue machine counts people entering at the front-end photocell and leaving at the back-end photocell; this block decides which teller calls the next person.
- It calls the head of the queue to a free, in-service teller using round-robin, then waits for the back-end photocell to confirm departure, with a no-show timeout.
- It sits beside the queue machine, shares T_Count, BE_photocell and empt_flag with it, and drives the caller display.

Parameters:
- TIMEOUT_CYC, 16: cycles spent in WAIT without a BE_photocell rising edge before the call is declared a no-show (minimum 2).
- TICKET_W, 4: width of the call ticket counter.

Ports:
- clck  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- T_Count  input  2  tellers in service: 00 none, 01 teller0, 10 teller0-1, 11 teller0-2
- empt_flag  input  1  queue empty, from queue machine
- BE_photocell  input  1  back-end sensor level; a person leaving the queue produces a rising edge
- teller_done  input  3  one-cycle pulse per teller: customer finished, teller becomes free
- call_valid  output  1  a call is being displayed
- call_teller  output  2  called teller number 1..3; 0 when no call
- call_ticket  output  TICKET_W  ticket number of the current or next call
- busy  output  3  per-teller serving flag
- served  output  1  one-cycle pulse: called person confirmed at back-end
- noshow  output  1  one-cycle pulse: call timed out

Behaviour:
- Reset (rst=0, asynchronous): FSM goes to IDLE. The following are all 0: call_valid, call_teller, call_ticket, busy, served, noshow, the BE edge register, the timer and the round-robin pointer (pointer targets teller0).
- Active mask: T_Count 00→000, 01→001, 10→011, 11→111.
- Eligible set: active mask AND NOT busy, using registered busy.
- BE edge: BE_photocell=1 and the previous-cycle sample=0. Registered internally; no synchroniser in this block.
- FSM IDLE:
  - Transition condition: eligible≠0 and empt_flag=0.
  - Grant: the first eligible teller at or after the pointer, wrapping 2→0.
  - At that clock edge: call_valid←1, call_teller←index+1, timer←0, pointer←index+1 (mod 3), state←WAIT.
  - Outputs change one clock after the condition is sampled.
- FSM WAIT:
  - Timer increments every cycle.
  - On a BE edge: busy[index]←1, served pulse, call_ticket+1, call_valid←0, call_teller←0, state←IDLE.
  - Else, when timer=TIMEOUT_CYC-1: noshow pulse, call_ticket+1 (ticket skipped), call_valid←0, call_teller←0, busy unchanged, state←IDLE.
  - A BE edge and timeout in the same cycle count as served; no noshow.
- A BE edge in IDLE is ignored: no pulse, no state change.
- empt_flag rising during WAIT has no effect; the call still resolves by BE edge or timeout.
- teller_done[i]: busy[i]←0 at the next edge. This applies in any state and is independent of the active mask.
- teller_done[i] on the same cycle as a BE edge granting teller i cannot occur, because a busy teller is never granted. If it is forced anyway, the set wins.
- T_Count reduced while a teller is busy: busy is held until teller_done. That teller is never granted again while inactive.
- T_Count reduced during WAIT for a now-inactive teller: the call completes normally.
- T_Count=00: no grants; the FSM stays in IDLE.
- call_ticket wraps modulo 2^TICKET_W with no flag.
- served and noshow are never high together and last exactly one cycle.
- Minimum call-to-call spacing is 2 cycles: WAIT exit, then IDLE grant.
- Reset mid-WAIT: call cleared immediately. No served/noshow pulse is produced.

Test Plan:
- Reset then release; T_Count=11, empt_flag=0, BE low → call_valid=1, call_teller=1, call_ticket=0 one cycle after release. BE edge 3 cycles later → served pulse, busy=001, ticket=1, next call to teller 2.
- Round-robin: T_Count=11, confirm each call by BE edge with no teller_done → calls to teller 1,2,3, then busy=111, call_valid stays 0. teller_done=010 → next call_teller=2.
- Timeout: a call issued with no BE edge → noshow pulse exactly TIMEOUT_CYC cycles after call_valid rose, busy unchanged, ticket advanced, next call goes to the next teller after the pointer.
- Simultaneous: BE edge on the cycle timer=TIMEOUT_CYC-1 → served=1, noshow=0.
- Boundaries:
  - T_Count=01 → only teller 1 is ever called.
  - T_Count=00 or empt_flag=1 → no call.
  - 17 confirmed calls with TICKET_W=4 → ticket wraps 15→0.
- Reset asserted mid-WAIT → all outputs 0 asynchronously, before the next clock edge. After release the first call uses ticket 0 and teller 1.
